// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator layer stages.
package cnn_pkg;

    localparam int unsigned FLEN_W  = 6;
    localparam int unsigned CH_W    = 9;
    localparam int unsigned CNT_W   = 19;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned LANE_W  = 2;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/quant_relu_sat.sv
// Requantizer: rounding arithmetic right shift, optional ReLU, int8 saturation.
module quant_relu_sat
    import cnn_pkg::*;
(
    input  logic [DATA_W-1:0]  acc,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [BYTE_W-1:0]  result
);

    // One guard bit so adding the rounding offset cannot overflow.
    localparam int unsigned EXT_W = DATA_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(INT8_MAX);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(INT8_MIN);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;
    logic signed [EXT_W-1:0] clamped;

    // Round half toward +inf, shift, clamp and saturate.
    always_comb begin
        ext = $signed({acc[DATA_W-1], acc});
        rnd = '0;
        if (shift != '0) begin
            rnd = $signed(EXT_W'(1) << (shift - SHIFT_W'(1)));
        end
        sum     = ext + rnd;
        shifted = sum >>> shift;
        clamped = shifted;
        if (relu_en && shifted[EXT_W-1]) begin
            clamped = '0;
        end
        if (clamped > SAT_HI) begin
            result = BYTE_W'(INT8_MAX);
        end else if (clamped < SAT_LO) begin
            result = BYTE_W'(INT8_MIN);
        end else begin
            result = clamped[BYTE_W-1:0];
        end
    end

endmodule

// File: rtl/quant_relu_pack.sv
// Quantize/ReLU stage feeding the max-pool: packs four int8 results per output word.
module quant_relu_pack
    import cnn_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                                S_AXIS_TUSER,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                                M_AXIS_TUSER,
    output logic                                M_AXIS_TLAST,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    input  logic                                qr_start,
    output logic                                qr_done,
    input  logic [FLEN_W-1:0]                   flen,
    input  logic [CH_W-1:0]                     out_channel,
    input  logic [SHIFT_W-1:0]                  shift,
    input  logic                                relu_en
);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    total;
    logic [CNT_W-1:0]    in_cnt;
    logic [LANE_W-1:0]   lane;
    logic [3*BYTE_W-1:0] pack;
    logic [BYTE_W-1:0]   q;
    logic                start_c;
    logic                in_fire_c;
    logic                out_fire_c;
    logic                unused_ok;

    assign unused_ok    = ^{S_AXIS_TKEEP, S_AXIS_TUSER, S_AXIS_TLAST};
    assign M_AXIS_TKEEP = '1;
    assign M_AXIS_TUSER = 1'b0;

    quant_relu_sat u_sat (
        .acc     (S_AXIS_TDATA),
        .shift   (shift),
        .relu_en (relu_en),
        .result  (q)
    );

    // Accept while beats remain, except a lane-3 beat that would overwrite a stalled word.
    assign S_AXIS_TREADY = (state == RUN) && (in_cnt < total) &&
                           ((lane != 2'd3) || !M_AXIS_TVALID || M_AXIS_TREADY);
    assign in_fire_c     = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_fire_c    = M_AXIS_TVALID && M_AXIS_TREADY;
    assign start_c       = (state == IDLE) && qr_start;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (qr_start) state_next = RUN;
            RUN:     if (out_fire_c && M_AXIS_TLAST) state_next = DONE;
            DONE:    if (!qr_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Done flag follows the DONE state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qr_done <= 1'b0;
        end else begin
            qr_done <= (state_next == DONE);
        end
    end

    // Layer size, input counter and lane packing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total  <= '0;
            in_cnt <= '0;
            lane   <= '0;
            pack   <= '0;
        end else if (start_c) begin
            total  <= CNT_W'(flen) * CNT_W'(flen) * CNT_W'(out_channel);
            in_cnt <= '0;
            lane   <= '0;
            pack   <= '0;
        end else if (in_fire_c) begin
            in_cnt <= in_cnt + CNT_W'(1);
            lane   <= lane + LANE_W'(1);
            case (lane)
                2'd0:    pack[7:0]   <= q;
                2'd1:    pack[15:8]  <= q;
                2'd2:    pack[23:16] <= q;
                default: pack        <= pack;
            endcase
        end
    end

    // Output word register; a new word may load in the cycle the old one drains.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (in_fire_c && (lane == 2'd3)) begin
            M_AXIS_TDATA  <= {q, pack};
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= (in_cnt == total - CNT_W'(1));
        end else if (out_fire_c) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
        end
    end

endmodule
